// File: rtl/decipher_stream_io.sv
// Byte-serial wrapper around a combinational AES-128 decipher: gathers 16 ciphertext bytes,
// waits a fixed settle window on the multicycle path, then streams the 16 plaintext bytes back out.
module decipher_stream_io #(
    parameter int N      = 128,
    parameter int SETTLE = 2      // legal range 1..15
) (
    input  logic           clk,
    input  logic           rst,
    input  logic [N-1:0]   key_in,
    input  logic           key_load,
    input  logic [7:0]     in_byte,
    input  logic           in_valid,
    output logic           in_ready,
    output logic [7:0]     out_byte,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [127:0]   dec_in,
    output logic [N-1:0]   dec_key,
    input  logic [127:0]   dec_out,
    output logic           busy
);

    typedef enum logic [1:0] {
        ST_LOAD,
        ST_SETTLE,
        ST_SEND
    } state_t;

    localparam logic [3:0] SETTLE_LAST = 4'(SETTLE - 1);

    state_t         state;
    logic [3:0]     bcnt;
    logic [3:0]     scnt;
    logic [127:0]   in_sr;
    logic [127:0]   out_sr;
    logic [N-1:0]   key_r;
    logic           in_fire;
    logic           out_fire;

    assign in_ready = (state == ST_LOAD) && !rst;
    assign in_fire  = in_valid && in_ready;
    assign out_fire = out_valid && out_ready;

    // NOTE: every register here updates with <= so all of them see pre-edge values of each other;
    // the shift registers double as the wide datapath registers, so the reset clears them too.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_LOAD;
            bcnt      <= 4'd0;
            scnt      <= 4'd0;
            in_sr     <= '0;
            out_sr    <= '0;
            key_r     <= '0;
            out_valid <= 1'b0;
        end else begin
            case (state)
                ST_LOAD: begin
                    // Key may only change before the first byte, so the decipher never sees a mid-block key
                    if (key_load && bcnt == 4'd0) key_r <= key_in;
                    if (in_fire) begin
                        in_sr <= {in_sr[119:0], in_byte};
                        if (bcnt == 4'd15) begin
                            bcnt  <= 4'd0;
                            scnt  <= 4'd0;
                            state <= ST_SETTLE;
                        end else begin
                            bcnt <= bcnt + 4'd1;
                        end
                    end
                end
                ST_SETTLE: begin
                    if (scnt == SETTLE_LAST) begin
                        out_sr    <= dec_out;
                        out_valid <= 1'b1;
                        state     <= ST_SEND;
                    end else begin
                        scnt <= scnt + 4'd1;
                    end
                end
                ST_SEND: begin
                    if (out_fire) begin
                        out_sr <= {out_sr[119:0], 8'h00};
                        if (bcnt == 4'd15) begin
                            bcnt      <= 4'd0;
                            out_valid <= 1'b0;
                            state     <= ST_LOAD;
                        end else begin
                            bcnt <= bcnt + 4'd1;
                        end
                    end
                end
                default: state <= ST_LOAD;
            endcase
        end
    end

    assign out_byte = out_sr[127:120];
    assign dec_in   = in_sr;
    assign dec_key  = key_r;
    assign busy     = (state != ST_LOAD) || (bcnt != 4'd0);

endmodule

// File: tb/tb_decipher_stream_io.sv
// Bench for decipher_stream_io: a behavioural AES-128 decipher with a settle window feeds two DUTs
// (SETTLE=2 and SETTLE=1); a per-cycle transaction model checks every output.
module tb_decipher_stream_io;

    localparam int NU = 2;
    localparam logic [127:0] KEY_A = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] CT_A  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] PT_A  = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] KEY_B = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] CT_B  = 128'h3925841d02dc09fbdc118597196a0b32;
    localparam logic [127:0] PT_B  = 128'h3243f6a8885a308d313198a2e0370734;
    localparam logic [127:0] KEY_X = 128'hdeadbeef0badf00dcafe123456789abc;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic [NU-1:0]          rst, key_load, in_valid, out_ready;
    logic [NU-1:0][127:0]   key_in, dec_out;
    logic [NU-1:0][7:0]     in_byte;
    wire  [NU-1:0]          in_ready, out_valid, busy;
    wire  [NU-1:0][127:0]   dec_in, dec_key;
    wire  [NU-1:0][7:0]     out_byte;

    for (genvar g = 0; g < NU; g++) begin : g_dut
        decipher_stream_io #(.N(128), .SETTLE(g == 0 ? 2 : 1)) dut (
            .clk(clk), .rst(rst[g]), .key_in(key_in[g]), .key_load(key_load[g]),
            .in_byte(in_byte[g]), .in_valid(in_valid[g]), .in_ready(in_ready[g]),
            .out_byte(out_byte[g]), .out_valid(out_valid[g]), .out_ready(out_ready[g]),
            .dec_in(dec_in[g]), .dec_key(dec_key[g]), .dec_out(dec_out[g]), .busy(busy[g])
        );
    end

    int n_cmp = 0;
    int n_fail = 0;
    int cyc = 0;
    bit chk_on = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic int settle_of(input int u);
        return (u == 0) ? 2 : 1;
    endfunction

    task automatic check(input string name, input int u, input logic [127:0] act, input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s[u%0d] @cyc %0d: got %h required %h", name, u, cyc, act, exp);
        end
    endtask

    task automatic timeout_fail(input string name, input int u);
        n_cmp++;
        n_fail++;
        $display("FAIL %s[u%0d] @cyc %0d: got no handshake, required one within bound", name, u, cyc);
    endtask

    // ---------------- behavioural AES-128 inverse cipher ----------------
    logic [7:0] sbox [256];
    logic [7:0] isbox [256];

    function automatic logic [7:0] xt(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p, x, y;
        p = 8'h00; x = a; y = b;
        for (int i = 0; i < 8; i++) begin
            if (y[0]) p = p ^ x;
            x = xt(x);
            y = y >> 1;
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
        logic [15:0] t;
        t = {b, b} << n;
        return t[15:8];
    endfunction

    task automatic init_tables();
        logic [7:0] inv, s, x;
        for (int v = 0; v < 256; v++) begin
            x = 8'(v);
            inv = 8'h01;
            repeat (254) inv = gmul(inv, x);   // x^254 is the field inverse (0 maps to 0)
            s = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
            sbox[v] = s;
            isbox[s] = x;
        end
    endtask

    function automatic logic [127:0] aes_dec(input logic [127:0] ct, input logic [127:0] key);
        logic [31:0]  w [44];
        logic [7:0]   s [16];
        logic [7:0]   t [16];
        logic [31:0]  tmp;
        logic [7:0]   rc, a0, a1, a2, a3;
        logic [127:0] res;
        rc = 8'h01;
        for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
        for (int i = 4; i < 44; i++) begin
            tmp = w[i-1];
            if (i % 4 == 0) begin
                tmp = {sbox[tmp[23:16]], sbox[tmp[15:8]], sbox[tmp[7:0]], sbox[tmp[31:24]]} ^ {rc, 24'h0};
                rc = xt(rc);
            end
            w[i] = w[i-4] ^ tmp;
        end
        for (int i = 0; i < 16; i++) s[i] = ct[127-8*i -: 8];
        for (int r = 10; r >= 0; r--) begin
            if (r != 10) begin
                for (int i = 0; i < 16; i++) t[i] = isbox[s[(i % 4) + 4 * (((i / 4) - (i % 4) + 4) % 4)]];
                s = t;
            end
            for (int i = 0; i < 16; i++) begin
                tmp = w[4*r + i/4];
                s[i] = s[i] ^ tmp[31-8*(i%4) -: 8];
            end
            if (r != 10 && r != 0) begin
                for (int c = 0; c < 4; c++) begin
                    a0 = s[4*c]; a1 = s[4*c+1]; a2 = s[4*c+2]; a3 = s[4*c+3];
                    s[4*c]   = gmul(a0, 8'h0e) ^ gmul(a1, 8'h0b) ^ gmul(a2, 8'h0d) ^ gmul(a3, 8'h09);
                    s[4*c+1] = gmul(a0, 8'h09) ^ gmul(a1, 8'h0e) ^ gmul(a2, 8'h0b) ^ gmul(a3, 8'h0d);
                    s[4*c+2] = gmul(a0, 8'h0d) ^ gmul(a1, 8'h09) ^ gmul(a2, 8'h0e) ^ gmul(a3, 8'h0b);
                    s[4*c+3] = gmul(a0, 8'h0b) ^ gmul(a1, 8'h0d) ^ gmul(a2, 8'h09) ^ gmul(a3, 8'h0e);
                end
            end
        end
        for (int i = 0; i < 16; i++) res[127-8*i -: 8] = s[i];
        return res;
    endfunction

    // Decipher stand-in: output is wrong until its inputs have been stable for SETTLE cycles
    logic [NU-1:0][127:0] prev_in, prev_key, aes_val;
    int age [NU];

    initial begin
        forever begin
            @(negedge clk);
            for (int u = 0; u < NU; u++) begin
                if (dec_in[u] !== prev_in[u] || dec_key[u] !== prev_key[u]) begin
                    prev_in[u]  = dec_in[u];
                    prev_key[u] = dec_key[u];
                    aes_val[u]  = aes_dec(dec_in[u], dec_key[u]);
                    age[u]      = 1;
                end else if (age[u] < 15) begin
                    age[u] = age[u] + 1;
                end
                dec_out[u] = (age[u] >= settle_of(u)) ? aes_val[u] : ~aes_val[u];
            end
        end
    end

    // ---------------- transaction-level model + per-cycle compare ----------------
    int           m_icnt [NU];
    int           m_ocnt [NU];
    int           m_t16  [NU];
    bit           m_done [NU];
    logic [127:0] m_hist [NU];
    logic [127:0] m_key  [NU];
    logic [127:0] m_pt   [NU];

    initial begin
        bit loading, sending;
        forever begin
            @(negedge clk);
            for (int u = 0; u < NU; u++) begin
                loading = !m_done[u];
                sending = m_done[u] && (cyc > m_t16[u] + settle_of(u));
                if (chk_on) begin
                    check("in_ready", u, in_ready[u], loading && !rst[u]);
                    check("out_valid", u, out_valid[u], sending);
                    check("busy", u, busy[u], !loading || m_icnt[u] != 0);
                    check("dec_in", u, dec_in[u], m_hist[u]);
                    check("dec_key", u, dec_key[u], m_key[u]);
                    if (sending) check("out_byte", u, out_byte[u], m_pt[u][127-8*m_ocnt[u] -: 8]);
                end
                if (rst[u]) begin
                    m_icnt[u] = 0; m_ocnt[u] = 0; m_done[u] = 1'b0;
                    m_hist[u] = '0; m_key[u] = '0;
                end else if (loading) begin
                    if (key_load[u] && m_icnt[u] == 0) m_key[u] = key_in[u];
                    if (in_valid[u]) begin
                        m_hist[u] = {m_hist[u][119:0], in_byte[u]};
                        m_icnt[u] = m_icnt[u] + 1;
                        if (m_icnt[u] == 16) begin
                            m_icnt[u] = 0;
                            m_done[u] = 1'b1;
                            m_t16[u]  = cyc;
                            m_pt[u]   = aes_dec(m_hist[u], m_key[u]);
                        end
                    end
                end else if (sending && out_ready[u]) begin
                    m_ocnt[u] = m_ocnt[u] + 1;
                    if (m_ocnt[u] == 16) begin
                        m_ocnt[u] = 0;
                        m_done[u] = 1'b0;
                    end
                end
            end
        end
    end

    // ---------------- drivers (enter and leave just after a rising edge) ----------------
    task automatic send_block(input int u, input logic [127:0] ct, input bit ldkey, input logic [127:0] key,
                              input int gap_max, input int lock_at, output int first_hs, output int last_hs);
        int t;
        first_hs = -1;
        last_hs  = -1;
        for (int i = 0; i < 16; i++) begin
            repeat ((gap_max > 0) ? $urandom_range(gap_max, 0) : 0) begin
                in_valid[u] = 1'b0;
                @(posedge clk); #1;
            end
            in_valid[u] = 1'b1;
            in_byte[u]  = ct[127-8*i -: 8];
            key_load[u] = (ldkey && i == 0) || (i == lock_at);
            key_in[u]   = (i == lock_at) ? KEY_X : key;
            t = 0;
            @(negedge clk);
            while (!in_ready[u]) begin
                t++;
                if (t > 400) begin
                    timeout_fail("in_handshake", u);
                    return;
                end
                @(negedge clk);
            end
            if (i == 0) first_hs = cyc;
            last_hs = cyc;
            @(posedge clk); #1;
            in_valid[u] = 1'b0;
            key_load[u] = 1'b0;
        end
    endtask

    task automatic recv_block(input int u, input bit rand_rdy, input bit spam, input int abort_at,
                              output logic [127:0] pt, output int first_vld, output int last_hs);
        int n, t;
        bit spamming;
        n = 0; t = 0; spamming = 1'b0;
        pt = '0; first_vld = -1; last_hs = -1;
        while (n < 16) begin
            if (n == abort_at) begin
                rst[u] = 1'b1;
                out_ready[u] = 1'b1;
                @(posedge clk); #1;
                rst[u] = 1'b0;
                out_ready[u] = 1'b0;
                return;
            end
            out_ready[u] = rand_rdy ? 1'($urandom_range(1, 0)) : 1'b1;
            if (spam && out_valid[u]) begin
                key_load[u] = 1'b1;
                key_in[u]   = KEY_X;
                spamming    = 1'b1;
            end
            @(negedge clk);
            if (out_valid[u] && first_vld < 0) first_vld = cyc;
            if (out_valid[u] && out_ready[u]) begin
                pt[127-8*n -: 8] = out_byte[u];
                n++;
                last_hs = cyc;
            end
            t++;
            if (t > 1000) begin
                timeout_fail("out_handshake", u);
                return;
            end
            @(posedge clk); #1;
        end
        if (spamming) key_load[u] = 1'b0;
        out_ready[u] = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation still running at %0t, required completion", $time);
        $fatal(1, "watchdog expired");
    end

    // ---------------- test sequence ----------------
    initial begin
        logic [127:0] pt, pt2, rkey, rct;
        int f1, l1, v1, h1, f2, l2, v2, h2;
        rst = '1; key_load = '0; in_valid = '0; out_ready = '0;
        key_in = '0; in_byte = '0; dec_out = '0;
        for (int u = 0; u < NU; u++) begin
            prev_in[u] = '1; prev_key[u] = '1; aes_val[u] = '0; age[u] = 0;
            m_icnt[u] = 0; m_ocnt[u] = 0; m_t16[u] = -100; m_done[u] = 1'b0;
            m_hist[u] = '0; m_key[u] = '0; m_pt[u] = '0;
        end
        init_tables();

        // Reset state, literal
        @(posedge clk); #1;
        chk_on = 1'b1;
        @(negedge clk);
        check("rst_in_ready", 0, in_ready[0], 1'b0);
        check("rst_out_valid", 0, out_valid[0], 1'b0);
        check("rst_busy", 0, busy[0], 1'b0);
        check("rst_dec_key", 0, dec_key[0], '0);
        check("rst_out_byte", 0, out_byte[0], 8'h00);
        @(posedge clk); #1;
        rst = '0;
        @(negedge clk);
        check("post_rst_in_ready", 0, in_ready[0], 1'b1);
        @(posedge clk); #1;

        // FIPS-197 C.1 vector, latency SETTLE+1 = 3
        fork
            send_block(0, CT_A, 1'b1, KEY_A, 0, -1, f1, l1);
            recv_block(0, 1'b0, 1'b0, -1, pt, v1, h1);
        join
        check("fips_pt", 0, pt, PT_A);
        check("fips_latency", 0, v1 - l1, 3);
        @(negedge clk);
        check("fips_key_hold", 0, dec_key[0], KEY_A);
        check("fips_in_hold", 0, dec_in[0], CT_A);
        @(posedge clk); #1;

        // Back-pressure and gapped input, key retained
        repeat (3) begin
            fork
                send_block(0, CT_A, 1'b0, '0, 3, -1, f1, l1);
                recv_block(0, 1'b1, 1'b0, -1, pt, v1, h1);
            join
            check("bp_pt", 0, pt, PT_A);
        end

        // Key lock: load at bcnt=5 and throughout SEND are ignored
        fork
            send_block(0, CT_A, 1'b0, '0, 0, 5, f1, l1);
            recv_block(0, 1'b0, 1'b1, -1, pt, v1, h1);
        join
        check("lock_pt", 0, pt, PT_A);
        @(negedge clk);
        check("lock_key", 0, dec_key[0], KEY_A);
        @(posedge clk); #1;

        // Key load together with byte 0 applies to that block (FIPS-197 appendix B)
        fork
            send_block(0, CT_B, 1'b1, KEY_B, 0, -1, f1, l1);
            recv_block(0, 1'b1, 1'b0, -1, pt, v1, h1);
        join
        check("newkey_pt", 0, pt, PT_B);

        // Random keys/blocks with random stalls
        repeat (4) begin
            rkey = {$urandom, $urandom, $urandom, $urandom};
            rct  = {$urandom, $urandom, $urandom, $urandom};
            fork
                send_block(0, rct, 1'b1, rkey, 2, -1, f1, l1);
                recv_block(0, 1'b1, 1'b0, -1, pt, v1, h1);
            join
            check("rand_pt", 0, pt, aes_dec(rct, rkey));
        end

        // Reset at output byte 7
        fork
            send_block(0, CT_A, 1'b1, KEY_A, 0, -1, f1, l1);
            recv_block(0, 1'b0, 1'b0, 7, pt, v1, h1);
        join
        @(negedge clk);
        check("abort_out_valid", 0, out_valid[0], 1'b0);
        check("abort_busy", 0, busy[0], 1'b0);
        check("abort_dec_key", 0, dec_key[0], '0);
        check("abort_in_ready", 0, in_ready[0], 1'b1);
        @(posedge clk); #1;
        fork
            send_block(0, CT_B, 1'b1, KEY_B, 1, -1, f1, l1);
            recv_block(0, 1'b0, 1'b0, -1, pt, v1, h1);
        join
        check("after_abort_pt", 0, pt, PT_B);

        // Back-to-back blocks on the SETTLE=1 instance
        fork
            begin
                send_block(1, CT_A, 1'b1, KEY_A, 0, -1, f1, l1);
                send_block(1, CT_B, 1'b1, KEY_B, 0, -1, f2, l2);
            end
            begin
                recv_block(1, 1'b0, 1'b0, -1, pt, v1, h1);
                recv_block(1, 1'b0, 1'b0, -1, pt2, v2, h2);
            end
        join
        check("b2b_pt1", 1, pt, PT_A);
        check("b2b_pt2", 1, pt2, PT_B);
        check("b2b_latency1", 1, v1 - l1, 2);
        check("b2b_latency2", 1, v2 - l2, 2);
        check("b2b_next_accept", 1, f2 - h1, 1);

        repeat (3) @(posedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/decipher_stream_io.md
# decipher_stream_io

Byte-serial front/back end for the combinational 128-bit AES decipher. It assembles 16 ciphertext bytes from a valid/ready stream and holds the round key. It presents both to the decipher as stable parallel buses, waits a fixed settle window, then captures the 128-bit plaintext. It returns the plaintext as 16 bytes on a second valid/ready stream. It sits between the byte-wide host/UART path and the decipher datapath, and carries the decipher's multicycle path.

## Interface
- `N`, default 128: key width; must match the decipher's key width (128/192/256).
- `SETTLE`, default 2: cycles allowed for the decipher's combinational path to settle; legal range 1..15.

- `clk` input 1: single clock, all state updates on rising edge.
- `rst` input 1: synchronous, active-high reset.
- `key_in` input N: key value to load.
- `key_load` input 1: key load strobe.
- `in_byte` input 8: ciphertext byte.
- `in_valid` input 1: `in_byte` is valid.
- `in_ready` output 1: block accepts an input byte this cycle.
- `out_byte` output 8: plaintext byte.
- `out_valid` output 1: `out_byte` is valid.
- `out_ready` input 1: downstream accepts `out_byte`.
- `dec_in` output 128: ciphertext bus to the decipher `in` port.
- `dec_key` output N: key bus to the decipher `key` port.
- `dec_out` input 128: plaintext bus from the decipher `out` port.
- `busy` output 1: a block is in progress.

## Operation
- FSM states: LOAD, SETTLE, SEND. Byte counter `bcnt` is 4 bits; settle counter is 4 bits.
- **Reset.** State LOAD, `bcnt`=0, all registers cleared. `dec_in`=0, `dec_key`=0, `out_byte`=0, `out_valid`=0, `in_ready`=0 while `rst` is high, `busy`=0.
- **LOAD state.**
  - `in_ready`=1.
  - On `in_valid && in_ready`: input shift register <= {sr[119:0], in_byte}, and `bcnt` increments. The first byte ends in [127:120] (AES byte 0 at the MSB).
  - `dec_in` is the input shift register itself.
  - On the 16th accepted byte (`bcnt`=15): `bcnt`<=0 and state -> SETTLE.
- **Key load.**
  - The key register loads `key_in` only when `key_load`=1 in LOAD with `bcnt`=0. It is ignored in every other cycle; a key never changes mid-block.
  - A `key_load` and a first-byte handshake in the same cycle are both taken, and that block uses the new key.
  - `dec_key` is the key register.
- **SETTLE state.**
  - `in_ready`=0 and `out_valid`=0.
  - The counter runs for exactly `SETTLE` cycles.
  - At the clock edge ending the last SETTLE cycle: output register <= `dec_out`, and state -> SEND.
- **SEND state.**
  - `out_valid`=1 and `out_byte` = output register [127:120].
  - On `out_valid && out_ready`: output register shifts left 8 bits and `bcnt` increments.
  - After the 16th accepted byte: `bcnt`<=0, `out_valid` drops next cycle, and state -> LOAD.
- **Hold rules.** `dec_in` and `dec_key` are unchanged from the 16th input handshake until the next block's first input handshake. `in_valid` is ignored outside LOAD.
- **busy** = (state != LOAD) || (`bcnt` != 0).
- **Reset mid-operation.** `rst` in any state aborts the block. Partial input and pending output are discarded and the key register is cleared.

## Timing
- Let cycle k be the cycle of the 16th input handshake. State is SETTLE for cycles k+1..k+SETTLE.
- The capture edge ends cycle k+SETTLE. `out_valid`=1 from cycle k+SETTLE+1.
- Minimum block latency, from last input byte to first output byte, is SETTLE+1 cycles.
- With `out_ready` held at 1, output bytes appear on 16 consecutive cycles and `in_ready` rises the cycle after the last one.
- Throughput is one block per 16+SETTLE+16 cycles minimum. There is no overlap of LOAD with SEND.
- `out_byte` and `out_valid` are registered; there is no combinational path from `in_valid` or `out_ready` to any output.
- `out_byte` stays stable while `out_valid && !out_ready`.

## Test plan
- **FIPS-197 vector.** Bench uses a real AES-128 decipher. `key_load` key_in=000102030405060708090a0b0c0d0e0f, then bytes 69 c4 e0 d8 6a 7b 04 30 d8 cd b7 80 70 b4 c5 5a. Required response: `out_byte` 00 11 22 … ff in order, first `out_valid` exactly 3 cycles after the last input handshake.
- **Back-pressure.** `out_ready` toggled randomly and `in_valid` gapped randomly. Output bytes are unchanged while stalled and the same 16-byte plaintext results. `in_ready`=0 throughout SETTLE and SEND.
- **Key lock.** `key_load` with a different key asserted at `bcnt`=5 and during SEND is ignored: `dec_key` is unchanged and the plaintext is still 00112233…ff. `key_load` in the same cycle as byte 0 takes effect for that block.
- **Reset mid-block.** `rst` pulsed at output byte 7. Next cycle: `out_valid`=0, `busy`=0, `dec_key`=0, `in_ready`=1. A fresh key plus block then decrypts correctly.
- **Back-to-back with SETTLE=1.** Two blocks streamed with no gaps and `out_ready`=1. First output 2 cycles after the 16th input byte; the second block's first byte is accepted the cycle after the 16th output byte.
